knn_classifier_unit: RTL and testbench

KNN_CLASSIFIER_UNIT -- requirements
Module: knn_classifier_unit

---
 rtl/knn_pkg.sv | 29 ++
 rtl/knn_sorted_list.sv | 104 ++++++++++
 rtl/knn_classifier_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_knn_classifier_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared definitions for the k-nearest-neighbour classifier.
//   state_e      : controller state encoding
//   calc_dist_w  : width of a squared-distance sum over all coordinates
//   calc_cnt_w   : width of a vote counter that can hold 0..K
//   calc_idx_w   : index width for n items, never less than one bit
package knn_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAccum  = 3'd1,
        StInsert = 3'd2,
        StVote   = 3'd3,
        StDone   = 3'd4
    } state_e;

    function automatic int unsigned calc_dist_w(input int unsigned coord_w,
                                                input int unsigned n_coords);
        return 2 * coord_w + $clog2(n_coords);
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned k);
        return $clog2(k + 1);
    endfunction

    function automatic int unsigned calc_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/knn_sorted_list.sv
// Ascending list of the K nearest (distance, class) pairs seen so far.
//   clk, rst   : clock, synchronous active-high reset (empties the list)
//   clear      : empties the list
//   ins_valid  : insert ins_dist/ins_class this cycle
//   rd_idx     : slot to read; rd_class returns its class
//   count      : number of occupied slots (0..K)
//   head_dist  : slot-0 distance, only when KNN_MIN_DIST_OUT_EN is defined
// Equal distances land after existing entries, so the earliest point wins.
module knn_sorted_list
    import knn_pkg::*;
#(
    parameter int unsigned K       = 8,
    parameter int unsigned DIST_W  = 33,
    parameter int unsigned CLASS_W = 3,
    parameter int unsigned CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               ins_valid,
    input  logic [DIST_W-1:0]  ins_dist,
    input  logic [CLASS_W-1:0] ins_class,
    input  logic [CNT_W-1:0]   rd_idx,
    output logic [CLASS_W-1:0] rd_class,
`ifdef KNN_MIN_DIST_OUT_EN
    output logic [DIST_W-1:0]  head_dist,
`endif
    output logic [CNT_W-1:0]   count
);

    logic [DIST_W-1:0]  dist_q [K];
    logic [DIST_W-1:0]  dist_d [K];
    logic [CLASS_W-1:0] cls_q  [K];
    logic [CLASS_W-1:0] cls_d  [K];
    logic [K-1:0]       valid_q, valid_d;
    logic [CNT_W-1:0]   count_q, count_d;
    // keep[i]: slot i stays put; the list is sorted, so keep is a prefix
    logic [K-1:0]       keep, keep_prev;

    always_comb begin
        for (int i = 0; i < K; i++) begin
            keep[i] = valid_q[i] && (dist_q[i] <= ins_dist);
        end
        keep_prev = (keep << 1) | K'(1);
        dist_d  = dist_q;
        cls_d   = cls_q;
        valid_d = valid_q;
        count_d = count_q;
        if (clear) begin
            valid_d = '0;
            count_d = '0;
        end else if (ins_valid && !keep[K-1]) begin
            // first non-kept slot takes the new entry, the rest shift down one
            for (int i = 0; i < K; i++) begin
                if (!keep[i] && keep_prev[i]) begin
                    dist_d[i]  = ins_dist;
                    cls_d[i]   = ins_class;
                    valid_d[i] = 1'b1;
                end
            end
            for (int i = 1; i < K; i++) begin
                if (!keep[i] && !keep_prev[i]) begin
                    dist_d[i]  = dist_q[i-1];
                    cls_d[i]   = cls_q[i-1];
                    valid_d[i] = valid_q[i-1];
                end
            end
            if (count_q != CNT_W'(K)) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rd_class = '0;
        for (int i = 0; i < K; i++) begin
            if (rd_idx == CNT_W'(i)) begin
                rd_class = cls_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= '0;
                cls_q[i]  <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
        end else begin
            dist_q  <= dist_d;
            cls_q   <= cls_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
`ifdef KNN_MIN_DIST_OUT_EN
    assign head_dist = dist_q[0];
`endif

endmodule

// File: rtl/knn_classifier_unit.sv
// k-nearest-neighbour classifier: streams test/dataset coordinate pairs, keeps
// the K nearest points by squared Euclidean distance, then majority-votes.
//   clk, rst             : clock, synchronous active-high reset
//   start                : begin a run (accepted in idle/done only)
//   busy                 : run in progress
//   s_valid/s_ready      : coordinate beat handshake
//   s_test_coord         : test-point coordinate
//   s_data_coord         : dataset-point coordinate
//   s_class, s_last      : dataset class / last-point flag, final beat only
//   res_valid, res_class : result strobe and winning class
//   res_count, res_tie   : winning vote count, another class matched it
//   res_min_dist         : nearest distance (only with KNN_MIN_DIST_OUT_EN)
module knn_classifier_unit
    import knn_pkg::*;
#(
    parameter  int unsigned COORD_W  = 16,
    parameter  int unsigned CLASS_W  = 3,
    parameter  int unsigned K        = 8,
    parameter  int unsigned N_COORDS = 2,
    localparam int unsigned DIST_W   = calc_dist_w(COORD_W, N_COORDS),
    localparam int unsigned CNT_W    = calc_cnt_w(K)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [COORD_W-1:0] s_test_coord,
    input  logic [COORD_W-1:0] s_data_coord,
    input  logic [CLASS_W-1:0] s_class,
    input  logic               s_last,
`ifdef KNN_MIN_DIST_OUT_EN
    output logic [DIST_W-1:0]  res_min_dist,
`endif
    output logic               res_valid,
    output logic [CLASS_W-1:0] res_class,
    output logic [CNT_W-1:0]   res_count,
    output logic               res_tie
);

    localparam int unsigned CI_W    = calc_idx_w(N_COORDS);
    localparam int unsigned NUM_CLS = 1 << CLASS_W;

    state_e             state_q, state_d;
    logic [DIST_W-1:0]  acc_q, acc_d;
    logic [CI_W-1:0]    ci_q, ci_d;
    logic [CLASS_W-1:0] cls_q, cls_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   vote_idx_q, vote_idx_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CLS];
    logic [CNT_W-1:0]   cnt_d [NUM_CLS];
    logic [CNT_W-1:0]   max_q, max_d;
    logic [CLASS_W-1:0] win_q, win_d;
    logic               tie_q, tie_d;
    logic               res_valid_q, res_valid_d;
    logic [CLASS_W-1:0] res_class_q, res_class_d;
    logic [CNT_W-1:0]   res_count_q, res_count_d;
    logic               res_tie_q, res_tie_d;
`ifdef KNN_MIN_DIST_OUT_EN
    logic [DIST_W-1:0]  min_q, min_d;
    logic [DIST_W-1:0]  head_dist;
`endif

    logic               list_clear, ins_valid;
    logic [CLASS_W-1:0] list_cls;
    logic [CNT_W-1:0]   list_count;
    logic [COORD_W-1:0]   diff;
    logic [2*COORD_W-1:0] sq;
    logic [CNT_W-1:0]     vote_n;

    knn_sorted_list #(
        .K       (K),
        .DIST_W  (DIST_W),
        .CLASS_W (CLASS_W),
        .CNT_W   (CNT_W)
    ) u_list (
        .clk       (clk),
        .rst       (rst),
        .clear     (list_clear),
        .ins_valid (ins_valid),
        .ins_dist  (acc_q),
        .ins_class (cls_q),
        .rd_idx    (vote_idx_q),
        .rd_class  (list_cls),
`ifdef KNN_MIN_DIST_OUT_EN
        .head_dist (head_dist),
`endif
        .count     (list_count)
    );

    assign diff   = (s_test_coord >= s_data_coord) ? s_test_coord - s_data_coord
                                                   : s_data_coord - s_test_coord;
    assign sq     = diff * diff;
    assign vote_n = cnt_q[list_cls] + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ci_d        = ci_q;
        cls_d       = cls_q;
        last_d      = last_q;
        vote_idx_d  = vote_idx_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        win_d       = win_q;
        tie_d       = tie_q;
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        res_count_d = res_count_q;
        res_tie_d   = res_tie_q;
`ifdef KNN_MIN_DIST_OUT_EN
        min_d       = min_q;
`endif
        busy        = 1'b0;
        s_ready     = 1'b0;
        list_clear  = 1'b0;
        ins_valid   = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StAccum;
                    list_clear  = 1'b1;
                    acc_d       = '0;
                    ci_d        = '0;
                    vote_idx_d  = '0;
                    for (int c = 0; c < NUM_CLS; c++) cnt_d[c] = '0;
                    max_d       = '0;
                    win_d       = '0;
                    tie_d       = 1'b0;
                    res_valid_d = 1'b0;
                    res_class_d = '0;
                    res_count_d = '0;
                    res_tie_d   = 1'b0;
`ifdef KNN_MIN_DIST_OUT_EN
                    min_d       = '0;
`endif
                end
            end
            StAccum: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) begin
                    acc_d = acc_q + DIST_W'(sq);
                    if (ci_q == CI_W'(N_COORDS - 1)) begin
                        ci_d    = '0;
                        cls_d   = s_class;
                        last_d  = s_last;
                        state_d = StInsert;
                    end else begin
                        ci_d = ci_q + CI_W'(1);
                    end
                end
            end
            StInsert: begin
                busy       = 1'b1;
                ins_valid  = 1'b1;
                acc_d      = '0;
                vote_idx_d = '0;
                state_d    = last_q ? StVote : StAccum;
            end
            StVote: begin
                busy            = 1'b1;
                cnt_d[list_cls] = vote_n;
                if (vote_n > max_q) begin
                    max_d = vote_n;
                    win_d = list_cls;
                    tie_d = 1'b0;
                end else if (vote_n == max_q && list_cls != win_q) begin
                    tie_d = 1'b1;
                end
                vote_idx_d = vote_idx_q + CNT_W'(1);
                // at least one point was inserted, so list_count >= 1 here
                if (vote_idx_q == list_count - CNT_W'(1)) begin
                    state_d     = StDone;
                    res_valid_d = 1'b1;
                    res_class_d = win_d;
                    res_count_d = max_d;
                    res_tie_d   = tie_d;
`ifdef KNN_MIN_DIST_OUT_EN
                    min_d       = head_dist;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            ci_q        <= '0;
            cls_q       <= '0;
            last_q      <= 1'b0;
            vote_idx_q  <= '0;
            for (int c = 0; c < NUM_CLS; c++) cnt_q[c] <= '0;
            max_q       <= '0;
            win_q       <= '0;
            tie_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            res_count_q <= '0;
            res_tie_q   <= 1'b0;
`ifdef KNN_MIN_DIST_OUT_EN
            min_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ci_q        <= ci_d;
            cls_q       <= cls_d;
            last_q      <= last_d;
            vote_idx_q  <= vote_idx_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            win_q       <= win_d;
            tie_q       <= tie_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            res_count_q <= res_count_d;
            res_tie_q   <= res_tie_d;
`ifdef KNN_MIN_DIST_OUT_EN
            min_q       <= min_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_class = res_class_q;
    assign res_count = res_count_q;
    assign res_tie   = res_tie_q;
`ifdef KNN_MIN_DIST_OUT_EN
    assign res_min_dist = min_q;
`endif

endmodule

// File: tb/tb_knn_classifier_unit.sv
// Self-checking bench for knn_classifier_unit (COORD_W=8, CLASS_W=2, K=3,
// N_COORDS=2). Directed table vectors, hand sequences for gaps/mid-run start
// and reset during voting, then random runs against a queue-based model.
module tb_knn_classifier_unit;

    localparam int COORD_W  = 8;
    localparam int CLASS_W  = 2;
    localparam int K        = 3;
    localparam int N_COORDS = 2;
    localparam int DIST_W   = 17;
    localparam int CNT_W    = 2;

    logic               clk = 1'b0;
    logic               rst, start, s_valid, s_last;
    logic [COORD_W-1:0] s_test_coord, s_data_coord;
    logic [CLASS_W-1:0] s_class;
    logic               busy, s_ready, res_valid, res_tie;
    logic [CLASS_W-1:0] res_class;
    logic [CNT_W-1:0]   res_count;
`ifdef KNN_MIN_DIST_OUT_EN
    logic [DIST_W-1:0]  res_min_dist;
`endif

    always #5 clk = ~clk;

    knn_classifier_unit #(
        .COORD_W  (COORD_W),
        .CLASS_W  (CLASS_W),
        .K        (K),
        .N_COORDS (N_COORDS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_test_coord (s_test_coord),
        .s_data_coord (s_data_coord),
        .s_class      (s_class),
        .s_last       (s_last),
`ifdef KNN_MIN_DIST_OUT_EN
        .res_min_dist (res_min_dist),
`endif
        .res_valid    (res_valid),
        .res_class    (res_class),
        .res_count    (res_count),
        .res_tie      (res_tie)
    );

    typedef struct packed {
        logic [7:0]      tx, ty;
        logic [3:0]      n;
        logic [5:0][7:0] px, py;
        logic [5:0][1:0] pc;
        logic [1:0]      e_class;
        logic [1:0]      e_count;
        logic            e_tie;
        logic [16:0]     e_min;
    } vec_t;

    vec_t vecs [4];
    int   px [8];
    int   py [8];
    int   pc [8];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // one clock, then sample clear of the edge; result and busy are exclusive
    task automatic tick();
        @(posedge clk);
        #1;
        chk("busy_res_exclusive", longint'(busy && res_valid), 0);
    endtask

    // Reference: keep K nearest in arrival-stable order, then majority vote;
    // winner is the first class (nearest-first) to reach the top count.
    function automatic void model(input int tx, input int ty, input int n,
                                  output int cls, output int cnt,
                                  output int tie, output int mind);
        int qd[$];
        int qc[$];
        int counts[4];
        int runs[4];
        int mx, pos, d, ntop;
        for (int p = 0; p < n; p++) begin
            d   = (tx - px[p]) * (tx - px[p]) + (ty - py[p]) * (ty - py[p]);
            pos = qd.size();
            for (int j = 0; j < qd.size(); j++) begin
                if (qd[j] > d) begin
                    pos = j;
                    break;
                end
            end
            qd.insert(pos, d);
            qc.insert(pos, pc[p]);
            if (qd.size() > K) begin
                void'(qd.pop_back());
                void'(qc.pop_back());
            end
        end
        for (int c = 0; c < 4; c++) begin
            counts[c] = 0;
            runs[c]   = 0;
        end
        foreach (qc[j]) counts[qc[j]]++;
        mx = 0;
        for (int c = 0; c < 4; c++) if (counts[c] > mx) mx = counts[c];
        ntop = 0;
        for (int c = 0; c < 4; c++) if (counts[c] == mx) ntop++;
        cls = -1;
        foreach (qc[j]) begin
            runs[qc[j]]++;
            if (cls < 0 && runs[qc[j]] == mx) cls = qc[j];
        end
        cnt  = mx;
        tie  = (ntop > 1) ? 1 : 0;
        mind = qd[0];
    endfunction

    task automatic send_beat(input int tc, input int dc, input int cls, input int last,
                             input bit final_beat, input bit gaps, input bit pulse_start);
        int guard;
        if (gaps && $urandom_range(0, 2) == 0) begin
            s_valid = 1'b0;
            tick();
        end
        s_valid      = 1'b1;
        s_test_coord = 8'(tc);
        s_data_coord = 8'(dc);
        s_class      = 2'(cls);
        s_last       = last[0];
        start        = pulse_start;
        guard = 0;
        while (!s_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk("beat_ready", longint'(s_ready), 1);
        tick();
        start   = 1'b0;
        s_valid = 1'b0;
        if (final_beat) chk("insert_ready_low", longint'(s_ready), 0);
    endtask

    task automatic run_case(input int tx, input int ty, input int n,
                            input int ecls, input int ecnt, input int etie, input int emin,
                            input bit gaps, input bit midstart, input bit rst_in_vote);
        int lat;
        int occ;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", longint'(busy), 1);
        chk("res_cleared_on_start", longint'(res_valid), 0);
        for (int p = 0; p < n; p++) begin
            send_beat(tx, px[p], $urandom_range(0, 3), $urandom_range(0, 1), 1'b0, gaps,
                      midstart && (p == 1));
            send_beat(ty, py[p], pc[p], (p == n - 1) ? 1 : 0, 1'b1, gaps, 1'b0);
        end
        if (rst_in_vote) begin
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("rst_in_vote_outputs",
                longint'({busy, s_ready, res_valid, res_class, res_count, res_tie}), 0);
`ifdef KNN_MIN_DIST_OUT_EN
            chk("rst_in_vote_min_dist", longint'(res_min_dist), 0);
`endif
            return;
        end
        lat = 0;
        while (!res_valid && lat < 40) begin
            tick();
            lat++;
        end
        occ = (n < K) ? n : K;
        chk("done_latency", lat, 1 + occ);
        chk("res_class", longint'(res_class), ecls);
        chk("res_count", longint'(res_count), ecnt);
        chk("res_tie", longint'(res_tie), etie);
        chk("busy_low_in_done", longint'(busy), 0);
`ifdef KNN_MIN_DIST_OUT_EN
        chk("res_min_dist", longint'(res_min_dist), emin);
`endif
        tick();
        chk("res_held", longint'({res_valid, res_class, res_count}),
            longint'({1'b1, 2'(ecls), 2'(ecnt)}));
        if (emin < 0) $display("unexpected negative distance");
    endtask

    task automatic load_req033();
        px[0] = 10; py[0] = 11; pc[0] = 1;
        px[1] = 12; py[1] = 10; pc[1] = 1;
        px[2] = 0;  py[2] = 0;  pc[2] = 2;
        px[3] = 10; py[3] = 9;  pc[3] = 2;
    endtask

    initial begin
        int mc, mn, mt, md, n, tx, ty, rng;

        vecs[0] = '0;
        vecs[0].tx = 10; vecs[0].ty = 10; vecs[0].n = 4;
        vecs[0].px[0] = 10; vecs[0].py[0] = 11; vecs[0].pc[0] = 1;
        vecs[0].px[1] = 12; vecs[0].py[1] = 10; vecs[0].pc[1] = 1;
        vecs[0].px[2] = 0;  vecs[0].py[2] = 0;  vecs[0].pc[2] = 2;
        vecs[0].px[3] = 10; vecs[0].py[3] = 9;  vecs[0].pc[3] = 2;
        vecs[0].e_class = 1; vecs[0].e_count = 2; vecs[0].e_tie = 0; vecs[0].e_min = 1;

        vecs[1] = '0;
        vecs[1].tx = 10; vecs[1].ty = 10; vecs[1].n = 1;
        vecs[1].px[0] = 10; vecs[1].py[0] = 10; vecs[1].pc[0] = 3;
        vecs[1].e_class = 3; vecs[1].e_count = 1; vecs[1].e_tie = 0; vecs[1].e_min = 0;

        vecs[2] = '0;
        vecs[2].tx = 10; vecs[2].ty = 10; vecs[2].n = 3;
        vecs[2].px[0] = 11; vecs[2].py[0] = 10; vecs[2].pc[0] = 0;
        vecs[2].px[1] = 12; vecs[2].py[1] = 10; vecs[2].pc[1] = 1;
        vecs[2].px[2] = 13; vecs[2].py[2] = 10; vecs[2].pc[2] = 2;
        vecs[2].e_class = 0; vecs[2].e_count = 1; vecs[2].e_tie = 1; vecs[2].e_min = 1;

        vecs[3] = '0;
        vecs[3].tx = 0; vecs[3].ty = 0; vecs[3].n = 1;
        vecs[3].px[0] = 255; vecs[3].py[0] = 255; vecs[3].pc[0] = 1;
        vecs[3].e_class = 1; vecs[3].e_count = 1; vecs[3].e_tie = 0; vecs[3].e_min = 130050;

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        s_test_coord = '0; s_data_coord = '0; s_class = '0;
        tick();
        tick();
        chk("reset_outputs",
            longint'({busy, s_ready, res_valid, res_class, res_count, res_tie}), 0);
        rst = 1'b0;
        tick();
        chk("idle_ready_low", longint'(s_ready), 0);

        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < 6; p++) begin
                px[p] = int'(vecs[i].px[p]);
                py[p] = int'(vecs[i].py[p]);
                pc[p] = int'(vecs[i].pc[p]);
            end
            run_case(int'(vecs[i].tx), int'(vecs[i].ty), int'(vecs[i].n),
                     int'(vecs[i].e_class), int'(vecs[i].e_count), int'(vecs[i].e_tie),
                     int'(vecs[i].e_min), 1'b0, 1'b0, 1'b0);
        end

        // valid gaps plus a start pulse while accumulating
        load_req033();
        run_case(10, 10, 4, 1, 2, 0, 1, 1'b1, 1'b1, 1'b0);

        // reset while voting, then a clean rerun
        load_req033();
        run_case(10, 10, 4, 1, 2, 0, 1, 1'b0, 1'b0, 1'b1);
        load_req033();
        run_case(10, 10, 4, 1, 2, 0, 1, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            n   = $urandom_range(1, 6);
            rng = ($urandom_range(0, 1) == 0) ? 7 : 255;
            tx  = $urandom_range(0, rng);
            ty  = $urandom_range(0, rng);
            for (int p = 0; p < n; p++) begin
                px[p] = $urandom_range(0, rng);
                py[p] = $urandom_range(0, rng);
                pc[p] = $urandom_range(0, 3);
            end
            model(tx, ty, n, mc, mn, mt, md);
            run_case(tx, ty, n, mc, mn, mt, md, r[0], 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
